// File: rtl/miriscv_pkg.sv
// Shared constants and types for the miriscv pipeline control unit.
package miriscv_pkg;

  localparam int CU_MAX_STAGES = 8;

  function automatic int CU_FWD_W(input int stages);
    return (stages <= 2) ? 1 : $clog2(stages);
  endfunction

  typedef logic [$clog2(CU_MAX_STAGES)-1:0] cu_fwd_sel_t;

  // Result of the youngest-writer search for one source operand
  typedef struct packed {
    logic        hit;
    logic        rdy;
    cu_fwd_sel_t stage;
  } cu_haz_t;

endpackage

// File: rtl/miriscv_pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the control unit (slave).
interface miriscv_pipe_ctrl_if
  import miriscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int GPR_ADDR_W = 5,
  parameter int STAGES     = 4
);

  logic [XLEN-1:0]              boot_addr_i;
  logic [STAGES-1:0]            stall_req_i;
  logic [STAGES-1:0]            valid_i;
  logic [GPR_ADDR_W-1:0]        rs1_addr_i;
  logic [GPR_ADDR_W-1:0]        rs2_addr_i;
  logic                         rs1_req_i;
  logic                         rs2_req_i;
  logic [STAGES*GPR_ADDR_W-1:0] rd_addr_i;
  logic [STAGES-1:0]            rd_we_i;
  logic [STAGES-1:0]            rd_ready_i;
  logic                         sb_set_i;
  logic [GPR_ADDR_W-1:0]        sb_set_addr_i;
  logic                         sb_clr_i;
  logic [GPR_ADDR_W-1:0]        sb_clr_addr_i;
  logic                         prediction_i;
  logic                         br_j_taken_i;
  logic [XLEN-1:0]              target_pc_i;
  logic [XLEN-1:0]              next_pc_i;

  logic [STAGES-1:0]             stall_o;
  logic [STAGES-1:0]             kill_o;
  logic [CU_FWD_W(STAGES)-1:0]   fwd_sel_rs1_o;
  logic [CU_FWD_W(STAGES)-1:0]   fwd_sel_rs2_o;
  logic [XLEN-1:0]               force_pc_o;
  logic                          force_o;
  logic                          sb_busy_o;

  modport slave (
    input  boot_addr_i, stall_req_i, valid_i, rs1_addr_i, rs2_addr_i,
           rs1_req_i, rs2_req_i, rd_addr_i, rd_we_i, rd_ready_i,
           sb_set_i, sb_set_addr_i, sb_clr_i, sb_clr_addr_i,
           prediction_i, br_j_taken_i, target_pc_i, next_pc_i,
    output stall_o, kill_o, fwd_sel_rs1_o, fwd_sel_rs2_o,
           force_pc_o, force_o, sb_busy_o
  );

  modport master (
    output boot_addr_i, stall_req_i, valid_i, rs1_addr_i, rs2_addr_i,
           rs1_req_i, rs2_req_i, rd_addr_i, rd_we_i, rd_ready_i,
           sb_set_i, sb_set_addr_i, sb_clr_i, sb_clr_addr_i,
           prediction_i, br_j_taken_i, target_pc_i, next_pc_i,
    input  stall_o, kill_o, fwd_sel_rs1_o, fwd_sel_rs2_o,
           force_pc_o, force_o, sb_busy_o
  );

endinterface

// File: rtl/miriscv_pipe_scoreboard.sv
// Pending-writeback bit per GPR for long-latency ops (divider, LSU).
module miriscv_pipe_scoreboard
  import miriscv_pkg::*;
#(
  parameter int GPR_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_set,
  input  logic [GPR_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [GPR_ADDR_W-1:0] i_clr_addr,
  input  logic [GPR_ADDR_W-1:0] i_rs1_addr,
  input  logic [GPR_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_pend,
  output logic                  o_rs2_pend,
  output logic                  o_busy
);

  localparam int NREG = 1 << GPR_ADDR_W;

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  // x0 is hardwired to zero and must never appear pending
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set && (i_set_addr != '0)) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr)                       w_clr_mask[i_clr_addr] = 1'b1;
  end

  // Set is applied after clear so a same-address collision leaves the bit set
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pend <= '0;
    else       r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
  end

  assign o_rs1_pend = r_pend[i_rs1_addr];
  assign o_rs2_pend = r_pend[i_rs2_addr];
  assign o_busy     = |r_pend;

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// Parametrised pipeline controller: stalls, kills, forwarding select and PC redirect.
module miriscv_pipe_ctrl
  import miriscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int GPR_ADDR_W   = 5,
  parameter int STAGES       = 4,
  parameter int BOOT_CYCLES  = 2,
  parameter int FWD_EN       = 1,
  parameter int REG_REDIRECT = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  miriscv_pipe_ctrl_if.slave  io
);

  localparam int FWD_W = CU_FWD_W(STAGES);

  logic [3:0]        r_boot_cnt;
  logic              r_redir_vld;
  logic [XLEN-1:0]   r_redir_pc;

  logic              w_boot;
  cu_haz_t           w_haz1;
  cu_haz_t           w_haz2;
  logic              w_rs1_fwd;
  logic              w_rs2_fwd;
  logic              w_rs1_pend;
  logic              w_rs2_pend;
  logic              w_sb_busy;
  logic              w_haz_stall;
  logic              w_sb_stall;
  logic              w_mispredict;
  logic [XLEN-1:0]   w_redir_pc;
  logic [STAGES-1:0] w_stall_acc;
  logic [STAGES-1:0] w_stall;
  logic [STAGES-1:0] w_kill;

  // Scan oldest to youngest so the lowest matching stage is the one kept
  function automatic cu_haz_t haz_search(
    input logic [GPR_ADDR_W-1:0]        rs,
    input logic                         req,
    input logic [STAGES-1:0]            vld,
    input logic [STAGES-1:0]            we,
    input logic [STAGES-1:0]            rdy,
    input logic [STAGES*GPR_ADDR_W-1:0] rd
  );
    cu_haz_t res;
    res = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (req && vld[0] && vld[k] && we[k] &&
          (rd[k*GPR_ADDR_W +: GPR_ADDR_W] == rs) && (rs != '0)) begin
        res.hit   = 1'b1;
        res.rdy   = rdy[k];
        res.stage = cu_fwd_sel_t'(k);
      end
    end
    return res;
  endfunction

  miriscv_pipe_scoreboard #(
    .GPR_ADDR_W (GPR_ADDR_W)
  ) u_sb (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_set      (io.sb_set_i),
    .i_set_addr (io.sb_set_addr_i),
    .i_clr      (io.sb_clr_i),
    .i_clr_addr (io.sb_clr_addr_i),
    .i_rs1_addr (io.rs1_addr_i),
    .i_rs2_addr (io.rs2_addr_i),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend),
    .o_busy     (w_sb_busy)
  );

  assign w_boot = (r_boot_cnt != 4'd0);

  always_comb begin
    w_haz1 = haz_search(io.rs1_addr_i, io.rs1_req_i, io.valid_i,
                        io.rd_we_i, io.rd_ready_i, io.rd_addr_i);
    w_haz2 = haz_search(io.rs2_addr_i, io.rs2_req_i, io.valid_i,
                        io.rd_we_i, io.rd_ready_i, io.rd_addr_i);
  end

  assign w_rs1_fwd   = w_haz1.hit & w_haz1.rdy & (FWD_EN != 0);
  assign w_rs2_fwd   = w_haz2.hit & w_haz2.rdy & (FWD_EN != 0);
  assign w_haz_stall = (w_haz1.hit & ~w_rs1_fwd) | (w_haz2.hit & ~w_rs2_fwd);

  // An in-flight pipeline writer is younger than any scoreboard entry
  assign w_sb_stall =
      (io.rs1_req_i & io.valid_i[0] & (io.rs1_addr_i != '0) & w_rs1_pend & ~w_haz1.hit) |
      (io.rs2_req_i & io.valid_i[0] & (io.rs2_addr_i != '0) & w_rs2_pend & ~w_haz2.hit);

  always_comb begin
    w_stall_acc[STAGES-1] = io.stall_req_i[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_stall_acc[i] = w_stall_acc[i+1] | io.stall_req_i[i];
    end
    w_stall    = w_stall_acc;
    w_stall[0] = w_stall_acc[0] | w_haz_stall | w_sb_stall;
  end

  assign w_mispredict = io.valid_i[STAGES-1] & ~io.stall_req_i[STAGES-1] &
                        (io.prediction_i ^ io.br_j_taken_i) & ~w_boot;
  assign w_redir_pc   = io.br_j_taken_i ? io.target_pc_i : io.next_pc_i;

  // With a registered redirect the fetch stage is killed again when force fires
  always_comb begin
    w_kill = '0;
    if (w_mispredict)                          w_kill    = '1;
    else if ((REG_REDIRECT != 0) && r_redir_vld) w_kill[0] = 1'b1;
  end

  always_comb begin
    io.stall_o       = '0;
    io.kill_o        = '0;
    io.fwd_sel_rs1_o = '0;
    io.fwd_sel_rs2_o = '0;
    io.force_o       = 1'b1;
    io.force_pc_o    = io.boot_addr_i;
    io.sb_busy_o     = w_sb_busy;
    if (!rst_i) begin
      io.kill_o        = w_kill;
      io.stall_o       = w_stall & ~w_kill;
      io.fwd_sel_rs1_o = w_rs1_fwd ? w_haz1.stage[FWD_W-1:0] : '0;
      io.fwd_sel_rs2_o = w_rs2_fwd ? w_haz2.stage[FWD_W-1:0] : '0;
      if (w_boot) begin
        io.force_o    = 1'b1;
        io.force_pc_o = io.boot_addr_i;
      end else if (REG_REDIRECT == 0) begin
        io.force_o    = w_mispredict;
        io.force_pc_o = w_redir_pc;
      end else begin
        io.force_o    = r_redir_vld;
        io.force_pc_o = r_redir_pc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_boot_cnt  <= 4'(BOOT_CYCLES);
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      if (w_boot) r_boot_cnt <= r_boot_cnt - 4'd1;
      r_redir_vld <= w_mispredict & (REG_REDIRECT != 0);
      if (w_mispredict) r_redir_pc <= w_redir_pc;
    end
  end

endmodule

// File: doc/miriscv_pipe_ctrl.md
Name: miriscv_pipe_ctrl

Overview:
Parametrised pipeline control unit for the miriscv core. It replaces the fixed 4-stage controller and supports a configurable stage count.
- Generates per-stage stall and kill signals and drives the PC redirect.
- Detects RAW hazards against every downstream stage, with optional operand forwarding.
- Tracks long-latency writebacks (divider, LSU) in a register scoreboard.
- Offers an optional registered redirect for timing closure.

Parameters:
XLEN, 32, data/PC width
GPR_ADDR_W, 5, register address width
STAGES, 4, number of pipeline stages; stage 0 is the operand-source stage, stage STAGES-1 resolves branches (range 3..8)
BOOT_CYCLES, 2, cycles after reset during which force_o is held with boot_addr_i (range 1..15)
FWD_EN, 1, 1 = resolve hazards by forwarding when the producer result is ready; 0 = always stall
REG_REDIRECT, 0, 1 = force_pc_o/force_o registered one cycle after the mispredict

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
boot_addr_i  in  XLEN  boot PC
stall_req_i  in  STAGES  per-stage stall request
valid_i  in  STAGES  per-stage valid
rs1_addr_i / rs2_addr_i  in  GPR_ADDR_W each  stage-0 source registers
rs1_req_i / rs2_req_i  in  1 each  source register actually read
rd_addr_i  in  STAGES*GPR_ADDR_W  destination register per stage (index 0 unused)
rd_we_i  in  STAGES  destination write enable per stage
rd_ready_i  in  STAGES  stage result available for forwarding
sb_set_i, sb_set_addr_i  in  1, GPR_ADDR_W  long-latency op issued, marks rd pending
sb_clr_i, sb_clr_addr_i  in  1, GPR_ADDR_W  long-latency writeback done
prediction_i, br_j_taken_i  in  1 each  last-stage predicted / actual taken
target_pc_i, next_pc_i  in  XLEN each  last-stage redirect targets
stall_o, kill_o  out  STAGES each  per-stage stall / kill
fwd_sel_rs1_o, fwd_sel_rs2_o  out  $clog2(STAGES) each  forward source stage; 0 = register file
force_pc_o  out  XLEN  redirect PC
force_o  out  1  redirect strobe
sb_busy_o  out  1  any scoreboard bit set

Behaviour:
- Reset (rst_i high at a clock edge):
  - boot counter := BOOT_CYCLES, scoreboard := 0, redirect register := 0.
  - Outputs during reset: stall_o=0, kill_o=0, force_o=1, force_pc_o=boot_addr_i, fwd_sel=0.
- Boot phase:
  - Boot is active while the counter is nonzero; the counter decrements each cycle.
  - While boot is active: force_o=1, force_pc_o=boot_addr_i; a mispredict is ignored.
  - Exactly BOOT_CYCLES force cycles follow reset deassertion.
- Hazard match for a source rs at stage k (k=1..STAGES-1): req & valid_i[0] & valid_i[k] & rd_we_i[k] & rd_addr[k]==rs & rs!=0.
  - Only the youngest (lowest k) match counts.
  - If FWD_EN and rd_ready_i[k]: fwd_sel=k, no stall. Otherwise hazard stall; fwd_sel=0.
  - No match: fwd_sel=0.
- Scoreboard stall: rs has its scoreboard bit set, no pipeline match, rs!=0.
  - A pipeline match takes priority, because it is the younger writer.
- Scoreboard update:
  - Set and clear to different addresses: both apply.
  - Set and clear to the same address in one cycle: set wins.
  - Address 0 is never set.
  - Kills do not clear the scoreboard.
- Stalls:
  - stall_o[i] = OR of stall_req_i[j] for j>=i.
  - stall_o[0] additionally ORs the hazard and scoreboard stalls.
- Mispredict = valid_i[STAGES-1] & ~stall_req_i[STAGES-1] & (prediction_i ^ br_j_taken_i) & ~boot.
- REG_REDIRECT=0:
  - On mispredict, kill_o = all ones and force_o=1 in the same cycle.
  - force_pc_o = target_pc_i if br_j_taken_i, else next_pc_i.
- REG_REDIRECT=1:
  - Mispredict cycle: kill_o = all ones; the selected PC is registered.
  - Next cycle: force_o=1 with the registered PC, and kill_o[0]=1 again to drop the wrong-path fetch.
  - A second mispredict in that next cycle is impossible because every stage is killed; it is not checked.
- Kill has priority over stall for the same stage.

Decomposition:
- miriscv_pkg gets the constants CU_MAX_STAGES=8 and CU_FWD_W(STAGES), plus a typedef cu_fwd_sel_t.
- One natural sub-module, miriscv_pipe_scoreboard: a 2^GPR_ADDR_W bit vector with set/clear/lookup ports and the busy output.
- The hazard priority search is a function inside this module.

Test Plan:
- Reset held 3 cycles, then released, BOOT_CYCLES=2 -> force_o=1 with force_pc_o=boot_addr_i=0x8000_0000 for exactly 2 cycles after release, then force_o=0.
- Stage 0 reads x5; stage 1 writes x5 with rd_ready=0 and stage 2 writes x5 with rd_ready=1, FWD_EN=1 -> stall_o[0]=1, stall_o[1]=0. Next cycle with stage 1 rd_ready=1 -> fwd_sel_rs1_o=1, no stall. rs=x0 -> never stalls.
- FWD_EN=0 with the same matches -> stall_o[0]=1 until stages 1..3 no longer write x5; fwd_sel always 0.
- sb_set x7, then stage 0 reads x7 -> stall_o[0]=1, sb_busy_o=1. sb_clr x7 -> stall drops the next cycle. Set and clear of x7 in the same cycle -> bit remains set.
- Last stage valid, prediction=0, taken=1, target=0x100 -> kill_o=4'b1111, force_o=1, force_pc_o=0x100. REG_REDIRECT=1 variant: force_o=1 one cycle later, with kill_o[0]=1 again.
- Mispredict while stall_req_i[3]=1 -> no kill until the stall releases. Stall_req_i[2]=1 -> stall_o=4'b0111.
